// File: rtl/draw_sprite.sv
// draw_sprite: streams a 16x16 sprite from a synchronous ROM to the VGA plot port with screen clipping
module draw_sprite #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [8:0] TRANSPARENT = 9'h1FF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       draw,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [1:0] facing,
  output logic [9:0] rom_addr,
  input  logic [8:0] rom_data,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [8:0] colour,
  output logic       plot,
  output logic       done
);
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FLUSH, S_DONE} state_t;
  localparam logic [8:0] XW = 9'(SCREEN_W);
  localparam logic [8:0] YH = 9'(SCREEN_H);
  state_t state;
  logic [7:0] bx;
  logic [6:0] by;
  logic [1:0] fac;
  logic [3:0] col, row, st_col, st_row;
  logic st_valid;
  logic [8:0] x_sum, y_sum;
  // sequencer: accepts a request, walks all 256 ROM addresses, then holds done until draw drops
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      bx <= '0;
      by <= '0;
      fac <= '0;
      col <= '0;
      row <= '0;
      st_col <= '0;
      st_row <= '0;
      st_valid <= 1'b0;
    end else begin
      st_valid <= state == S_DRAW && draw;
      st_col <= col;
      st_row <= row;
      case (state)
        S_IDLE: if (draw) begin
          bx <= base_x;
          by <= base_y;
          fac <= facing;
          col <= '0;
          row <= '0;
          state <= S_DRAW;
        end
        S_DRAW: if (!draw) state <= S_IDLE;
        else begin
          {row, col} <= {row, col} + 8'd1;
          if (&{row, col}) state <= S_FLUSH;
        end
        S_FLUSH: state <= draw ? S_DONE : S_IDLE;
        S_DONE: if (!draw) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  // plot stage: pairs the registered col/row with the ROM word that arrives one cycle after its address
  always_comb begin
    rom_addr = {fac, row, col};
    x_sum = {1'b0, bx} + {5'b0, st_col};
    y_sum = {2'b0, by} + {5'b0, st_row};
    x_out = x_sum[7:0];
    y_out = y_sum[6:0];
    colour = rom_data;
    plot = st_valid && rom_data != TRANSPARENT && x_sum < XW && y_sum < YH;
    done = state == S_DONE;
  end
endmodule

// File: tb/tb_draw_sprite.sv
// tb_draw_sprite: randomized passes checked against a per-pixel model of the sprite blit
module tb_draw_sprite;
  localparam int W = 160;
  localparam int H = 120;
  localparam logic [8:0] T = 9'h1FF;
  logic clock = 0, reset = 1, draw = 0;
  logic [7:0] base_x = 0;
  logic [6:0] base_y = 0;
  logic [1:0] facing = 0;
  logic [9:0] rom_addr;
  logic [8:0] rom_data = 0, colour;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic plot, done;
  logic [8:0] rom [1024];
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  always @(posedge clock) rom_data <= rom[rom_addr];
  draw_sprite dut (
    .clock(clock), .reset(reset), .draw(draw), .base_x(base_x), .base_y(base_y), .facing(facing),
    .rom_addr(rom_addr), .rom_data(rom_data), .x_out(x_out), .y_out(y_out), .colour(colour),
    .plot(plot), .done(done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic fill(input int mode);
    for (int i = 0; i < 1024; i++)
      rom[i] = mode == 0 ? 9'h003 : mode == 1 ? T : ($urandom_range(3) == 0 ? T : 9'($urandom_range(510)));
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_plot"}, plot, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, rom_addr, 0);
    check({tag, "_x"}, x_out, 0);
    check({tag, "_y"}, y_out, 0);
  endtask
  // one request; stop >= 0 drops draw right after pixel 'stop' is issued
  task automatic pass(input int bx, input int by, input int f, input int stop);
    int exp_plots, got_plots, last, pix, px, py;
    logic [8:0] c;
    logic exp;
    exp_plots = 0;
    got_plots = 0;
    last = stop >= 0 ? stop + 4 : 257;
    @(negedge clock);
    base_x = 8'(bx);
    base_y = 7'(by);
    facing = 2'(f);
    draw = 1;
    for (int k = 0; k <= last; k++) begin
      @(posedge clock);
      #1;
      if (k == 0) begin
        base_x = 8'($urandom);
        base_y = 7'($urandom);
        facing = 2'($urandom);
      end
      if (k < 256 && (stop < 0 || k <= stop)) check("rom_addr", rom_addr, f * 256 + k);
      pix = k - 1;
      exp = 0;
      if (pix >= 0 && pix < 256 && (stop < 0 || pix <= stop - 1)) begin
        px = bx + pix % 16;
        py = by + pix / 16;
        c = rom[f * 256 + pix];
        exp = c != T && px < W && py < H;
        if (exp) begin
          exp_plots++;
          check("x_out", x_out, px);
          check("y_out", y_out, py);
          check("colour", colour, c);
        end
      end
      if (pix >= 0 && pix < 256 || stop >= 0) check("plot", plot, exp);
      got_plots += int'(plot);
      check("done", done, stop < 0 && k == 257);
      if (k == stop) draw = 0;
    end
    draw = 0;
    @(posedge clock);
    #1;
    check("done_release", done, 0);
    check("plot_idle", plot, 0);
    check("plot_count", got_plots, exp_plots);
  endtask
  initial begin
    fill(1);
    #2;
    check_reset_outputs("rst_async");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    fill(0);
    pass(10, 20, 2, -1);
    fill(1);
    pass(10, 20, 2, -1);
    fill(0);
    pass(150, 112, 0, -1);
    pass(10, 20, 3, 100);
    pass(10, 20, 3, -1);
    @(negedge clock);
    base_x = 30;
    base_y = 40;
    facing = 1;
    draw = 1;
    repeat (60) @(posedge clock);
    @(negedge clock);
    check("pre_rst_plot", plot, 1);
    reset = 1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clock);
    check_reset_outputs("rst_hold");
    draw = 0;
    reset = 0;
    pass(5, 7, 1, -1);
    for (int i = 0; i < 8; i++) begin
      fill(2);
      pass($urandom_range(255), $urandom_range(127), $urandom_range(3), -1);
    end
    fill(2);
    pass(250, 115, 2, $urandom_range(30, 200));
    pass(0, 0, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_sprite.md
DRAW_SPRITE -- requirements
Module: draw_sprite

Interface
REQ-001 Parameter: SCREEN_W, 160, visible width in pixels; plot-space x range is 0..SCREEN_W-1.
REQ-002 Parameter: SCREEN_H, 120, visible height in pixels; plot-space y range is 0..SCREEN_H-1.
REQ-003 Parameter: TRANSPARENT, 9'h1FF, sprite colour code that is never plotted.
REQ-004 Port: clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: draw  in  1  level request from the game controller; high while the controller waits in its draw state.
REQ-007 Port: base_x  in  8  sprite top-left x; sampled only at request acceptance.
REQ-008 Port: base_y  in  7  sprite top-left y; sampled only at request acceptance.
REQ-009 Port: facing  in  2  sprite frame select (4 facings); sampled only at request acceptance.
REQ-010 Port: rom_addr  out  10  sprite ROM address {facing, row[3:0], col[3:0]}.
REQ-011 Port: rom_data  in  9  sprite ROM colour; synchronous ROM, valid exactly one cycle after rom_addr.
REQ-012 Port: x_out  out  8  plot x.
REQ-013 Port: y_out  out  7  plot y.
REQ-014 Port: colour  out  9  plot colour, equal to rom_data.
REQ-015 Port: plot  out  1  VGA write enable for the current x_out/y_out/colour.
REQ-016 Port: done  out  1  completion flag returned to the controller.

Function
REQ-017 The block SHALL implement states S_IDLE, S_DRAW, S_FLUSH and S_DONE.
REQ-018 S_IDLE: draw sampled high SHALL latch base_x, base_y and facing, clear a 4-bit column counter and a 4-bit row counter, and enter S_DRAW.
REQ-019 S_DRAW: each cycle SHALL issue rom_addr from the latched facing and the counters, then advance col; col wrap 15->0 SHALL increment row.
REQ-020 The issue of address row=15,col=15 SHALL be followed by the transition S_DRAW->S_FLUSH.
REQ-021 S_FLUSH SHALL last exactly one cycle and then enter S_DONE.
REQ-022 S_DONE: done SHALL be 1 while in this state; draw low SHALL return the block to S_IDLE, draw high SHALL keep it in S_DONE.
REQ-023 Stage register: each issued address SHALL register a valid bit and its col/row into a stage that pairs with rom_data one cycle later.
REQ-024 Plot coordinates SHALL be computed 9-bit wide: x_out = base_x+col, y_out = base_y+row, truncated onto the output ports.
REQ-025 plot SHALL be 1 only when all of the following hold: stage valid, rom_data != TRANSPARENT, full x sum < SCREEN_W, full y sum < SCREEN_H.
REQ-026 Off-screen pixels SHALL be skipped without stall (clipping); the cycle count SHALL NOT change.
REQ-027 Latency: with draw sampled at edge E0, pixel 0 is plotted between E1 and E2, pixel 255 between E256 and E257, and done is high from E257.
REQ-028 Abort: draw low while in S_DRAW or S_FLUSH SHALL return the block to S_IDLE at the next edge.
REQ-029 Abort: that same edge SHALL clear the stage valid bit and SHALL NOT assert done.
REQ-030 draw high on the same edge that S_DONE returns to S_IDLE SHALL NOT be possible; a new request is accepted only from S_IDLE.
REQ-031 Outside the state/counter pipeline, plot and done SHALL NOT depend combinationally on draw.

Reset
REQ-032 Asserting reset SHALL immediately set the state to S_IDLE, without waiting for a clock edge.
REQ-033 Asserting reset SHALL immediately clear the counters, the stage valid bit and the latched inputs.
REQ-034 While reset is high: plot=0, done=0, rom_addr=0, x_out=0, y_out=0.
REQ-035 Reset asserted mid-draw SHALL discard the operation; the first request after release SHALL start from pixel 0.

Verification
REQ-036 Opaque sprite (all 9'h003) at base 10,20 with facing=2 -> 256 plots covering x 10..25, y 20..35; rom_addr 512..767; done high in cycle 258 for exactly 1 cycle when draw drops on done.
REQ-037 ROM all TRANSPARENT -> zero plots; done timing identical to REQ-036.
REQ-038 Clipping case: base_x=150, base_y=112 -> plots only for x 150..159, y 112..119 (80 pixels); no wrapped x/y ever plotted.
REQ-039 Abort case: draw dropped at pixel 100 -> plot low from the next edge; done never asserted.
REQ-040 Abort recovery: a new draw after REQ-039 -> full 256-pixel pass.
REQ-041 Async reset case: reset pulsed between clock edges mid-draw -> plot/done low without waiting for an edge; a subsequent request completes normally.
